// File: rtl/wash_cycle_sequencer.sv
// Coin-started washing programme FSM (FILL, WASH, RINSE, SPIN) driving the shared phase timer.
// Registered outputs, one-cycle latency; define WM_PAUSE_EN to add pause/paused for freezing a running phase.
module wash_cycle_sequencer #(
  parameter int TW         = 32,
  parameter int FILL_TIME  = 5,
  parameter int WASH_TIME  = 5,
  parameter int RINSE_TIME = 2,
  parameter int SPIN_TIME  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_in,
  input  logic          double_wash,
  input  logic [1:0]    clk_freq_in,
  input  logic          timer_done,
`ifdef WM_PAUSE_EN
  input  logic          pause,
  output logic          paused,
`endif
  output logic          timer_start,
  output logic          timer_enable,
  output logic [TW-1:0] timer_value,
  output logic [1:0]    timer_freq,
  output logic [2:0]    phase,
  output logic          busy,
  output logic          door_lock,
  output logic          cycle_done
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DONE  = 3'd5
  } phase_t;

  phase_t        phase_q, phase_d;
  phase_t        next_timed;
  logic          start_q, start_d;
  logic          enable_q, enable_d;
  logic [TW-1:0] value_q, value_d;
  logic [1:0]    freq_q;
  logic          busy_q, busy_d;
  logic          lock_q, lock_d;
  logic          cdone_q, cdone_d;
  logic          dw_q, dw_d;
  logic          pass_q, pass_d;
  logic          done_seen;
  logic          pause_req;

`ifdef WM_PAUSE_EN
  logic          paused_q, paused_d;
  assign pause_req = pause;
`else
  assign pause_req = 1'b0;
`endif

  function automatic logic [TW-1:0] duration(input phase_t p);
    logic [TW-1:0] d;
    case (p)
      PH_FILL:  d = TW'(FILL_TIME);
      PH_WASH:  d = TW'(WASH_TIME);
      PH_RINSE: d = TW'(RINSE_TIME);
      PH_SPIN:  d = TW'(SPIN_TIME);
      default:  d = '0;
    endcase
    return d;
  endfunction

  // timer_done only counts once the timer has been loaded and is actually counting
  assign done_seen = enable_q && !start_q && timer_done;

  always_comb begin
    phase_d    = phase_q;
    start_d    = 1'b0;
    enable_d   = enable_q;
    value_d    = value_q;
    busy_d     = busy_q;
    lock_d     = lock_q;
    cdone_d    = 1'b0;
    dw_d       = dw_q;
    pass_d     = pass_q;
    next_timed = PH_IDLE;
`ifdef WM_PAUSE_EN
    paused_d   = 1'b0;
`endif

    case (phase_q)
      PH_FILL:  next_timed = PH_WASH;
      PH_WASH:  next_timed = PH_RINSE;
      PH_RINSE: next_timed = (dw_q && !pass_q) ? PH_WASH : PH_SPIN;
      PH_SPIN:  next_timed = PH_DONE;
      default:  next_timed = PH_IDLE;
    endcase

    case (phase_q)
      PH_IDLE: begin
        enable_d = 1'b0;
        busy_d   = 1'b0;
        lock_d   = 1'b0;
        if (coin_in) begin
          phase_d = PH_FILL;
          start_d = 1'b1;
          value_d = duration(PH_FILL);
          busy_d  = 1'b1;
          lock_d  = 1'b1;
          dw_d    = double_wash;
          pass_d  = 1'b0;
        end
      end

      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
        if (done_seen) begin
          enable_d = 1'b0;
          phase_d  = next_timed;
          if (next_timed == PH_DONE) begin
            cdone_d = 1'b1;
            busy_d  = 1'b0;
            lock_d  = 1'b0;
          end else begin
            start_d = 1'b1;
            value_d = duration(next_timed);
            if (phase_q == PH_RINSE && next_timed == PH_WASH)
              pass_d = 1'b1;
          end
        end else if (pause_req) begin
          // frozen: the timer keeps its count, so resuming needs no reload
          enable_d = 1'b0;
`ifdef WM_PAUSE_EN
          paused_d = 1'b1;
`endif
        end else begin
          enable_d = 1'b1;
        end
      end

      PH_DONE: begin
        phase_d  = PH_IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        lock_d   = 1'b0;
      end

      default: begin
        phase_d  = PH_IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        lock_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_IDLE;
      start_q  <= 1'b0;
      enable_q <= 1'b0;
      value_q  <= '0;
      freq_q   <= 2'd0;
      busy_q   <= 1'b0;
      lock_q   <= 1'b0;
      cdone_q  <= 1'b0;
      dw_q     <= 1'b0;
      pass_q   <= 1'b0;
`ifdef WM_PAUSE_EN
      paused_q <= 1'b0;
`endif
    end else begin
      phase_q  <= phase_d;
      start_q  <= start_d;
      enable_q <= enable_d;
      value_q  <= value_d;
      freq_q   <= clk_freq_in;
      busy_q   <= busy_d;
      lock_q   <= lock_d;
      cdone_q  <= cdone_d;
      dw_q     <= dw_d;
      pass_q   <= pass_d;
`ifdef WM_PAUSE_EN
      paused_q <= paused_d;
`endif
    end
  end

  assign phase        = phase_q;
  assign timer_start  = start_q;
  assign timer_enable = enable_q;
  assign timer_value  = value_q;
  assign timer_freq   = freq_q;
  assign busy         = busy_q;
  assign door_lock    = lock_q;
  assign cycle_done   = cdone_q;
`ifdef WM_PAUSE_EN
  assign paused       = paused_q;
`endif

endmodule
